// File: rtl/cpu_io_pkg.sv
// -----------------------------------------------------------------------------
// cpu_io_pkg
// Shared definitions for the CPU output path UART transmitter.
//   - tx_state_t       : transmitter FSM states
//   - BYTES_PER_WORD   : bytes serialised per 32-bit word
//   - DEFAULT_CLK_PER_BIT : 100 MHz / 115200 baud
// Configuration macro: OUTPUT_UART_TX_PARITY_EN (adds the PARITY state).
// -----------------------------------------------------------------------------
package cpu_io_pkg;

  localparam int BYTES_PER_WORD      = 4;
  localparam int DEFAULT_CLK_PER_BIT = 868;

`ifdef OUTPUT_UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP,
    PARITY
  } tx_state_t;
`else
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP
  } tx_state_t;
`endif

endpackage

// File: rtl/uart_byte_tx.sv
// -----------------------------------------------------------------------------
// uart_byte_tx
// Serialises one byte as start / 8 data bits LSB first / [even parity] / stop.
// A new byte can be accepted in IDLE or in the final cycle of STOP, so bytes
// presented on time go out back-to-back with no idle gap.
// Configuration macro: OUTPUT_UART_TX_PARITY_EN (8E1 instead of 8N1).
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   byte_data   : byte to send, sampled when byte_valid && byte_ready
//   byte_valid  : byte_data is offered
//   byte_ready  : engine can take a byte this cycle (combinational, does not
//                 depend on byte_valid)
//   txd         : registered serial line, idle high
// -----------------------------------------------------------------------------
module uart_byte_tx
  import cpu_io_pkg::*;
#(
  parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       txd
);

  tx_state_t   state_reg, state_next;
  logic [15:0] baud_reg, baud_next;
  logic [2:0]  bit_reg, bit_next;
  logic [7:0]  shift_reg, shift_next;
  logic        txd_reg, txd_next;
  logic        baud_wrap;
`ifdef OUTPUT_UART_TX_PARITY_EN
  logic        par_reg, par_next;
`endif

  assign baud_wrap = (baud_reg == 16'(CLK_PER_BIT - 1));

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_wrap ? 16'd0 : baud_reg + 16'd1;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    byte_ready = 1'b0;
`ifdef OUTPUT_UART_TX_PARITY_EN
    par_next   = par_reg;
`endif

    case (state_reg)
      IDLE: begin
        baud_next  = 16'd0;
        byte_ready = 1'b1;
        if (byte_valid) begin
          state_next = START;
          shift_next = byte_data;
          bit_next   = 3'd0;
`ifdef OUTPUT_UART_TX_PARITY_EN
          par_next   = ^byte_data;
`endif
        end
      end
      START: begin
        if (baud_wrap) state_next = DATA;
      end
      DATA: begin
        if (baud_wrap) begin
          shift_next = {1'b0, shift_reg[7:1]};
          bit_next   = bit_reg + 3'd1;
          if (bit_reg == 3'd7) begin
`ifdef OUTPUT_UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef OUTPUT_UART_TX_PARITY_EN
      PARITY: begin
        if (baud_wrap) state_next = STOP;
      end
`endif
      STOP: begin
        if (baud_wrap) begin
          // Last stop-bit cycle: chain straight into the next start bit.
          byte_ready = 1'b1;
          if (byte_valid) begin
            state_next = START;
            shift_next = byte_data;
            bit_next   = 3'd0;
`ifdef OUTPUT_UART_TX_PARITY_EN
            par_next   = ^byte_data;
`endif
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Line level is registered from the next state so txd changes exactly
    // on the cycle the state does, with no combinational glitches.
    case (state_next)
      START:   txd_next = 1'b0;
      DATA:    txd_next = shift_next[0];
`ifdef OUTPUT_UART_TX_PARITY_EN
      PARITY:  txd_next = par_next;
`endif
      default: txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      baud_reg  <= 16'd0;
      bit_reg   <= 3'd0;
      shift_reg <= 8'd0;
      txd_reg   <= 1'b1;
`ifdef OUTPUT_UART_TX_PARITY_EN
      par_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      txd_reg   <= txd_next;
`ifdef OUTPUT_UART_TX_PARITY_EN
      par_reg   <= par_next;
`endif
    end
  end

  assign txd = txd_reg;

endmodule

// File: rtl/output_uart_tx.sv
// -----------------------------------------------------------------------------
// output_uart_tx
// Host-facing end of the CPU output port. Buffers 32-bit words in a FIFO and
// streams each one to the PC as 4 UART bytes, least-significant byte first.
// Configuration macro: OUTPUT_UART_TX_PARITY_EN (8E1 frames, 44 bit-times per
// word instead of 40).
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   data_in     : word from the CPU output path
//   data_valid  : data_in valid this cycle
//   data_ready  : FIFO not full; accept on data_valid && data_ready
//   txd         : UART line, idle high
//   busy        : FIFO non-empty or a word in flight
//   overflow    : sticky, a word was offered while the FIFO was full
// -----------------------------------------------------------------------------
module output_uart_tx
  import cpu_io_pkg::*;
#(
  parameter int CLK_PER_BIT     = DEFAULT_CLK_PER_BIT,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic        txd,
  output logic        busy,
  output logic        overflow
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

  // ---------------------------------------------------------------- FIFO
  logic [31:0]              mem [DEPTH];
  logic [31:0]              head_reg;
  logic [FIFO_DEPTH_LOG2:0] wr_ptr_reg, rd_ptr_reg;
  logic                     full, empty, accept, pop;
  logic                     overflow_reg;

  assign full  = (wr_ptr_reg[FIFO_DEPTH_LOG2] != rd_ptr_reg[FIFO_DEPTH_LOG2]) &&
                 (wr_ptr_reg[FIFO_DEPTH_LOG2-1:0] == rd_ptr_reg[FIFO_DEPTH_LOG2-1:0]);
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign accept     = data_valid && !full;
  assign data_ready = !full;

  // Storage and registered head read. A word written on one edge is visible
  // in head_reg one edge later, which is exactly when LOAD samples it.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr_reg[FIFO_DEPTH_LOG2-1:0]] <= data_in;
    head_reg <= mem[rd_ptr_reg[FIFO_DEPTH_LOG2-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (accept) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)    rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (data_valid && full) overflow_reg <= 1'b1;
    end
  end

  assign overflow = overflow_reg;

  // ------------------------------------------------------ word sequencer
  // At word level only IDLE, LOAD and START are used: START means "a word is
  // on the line"; the per-bit START/DATA/PARITY/STOP phases live in the byte
  // engine below.
  tx_state_t   state_reg, state_next;
  logic [1:0]  idx_reg, idx_next;
  logic [23:0] rest_reg, rest_next;   // bytes still to send after the current one
  logic [7:0]  byte_data;
  logic        byte_valid, byte_ready;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    rest_next  = rest_reg;
    pop        = 1'b0;
    byte_valid = 1'b0;
    byte_data  = rest_reg[7:0];

    case (state_reg)
      IDLE: begin
        if (!empty) state_next = LOAD;
      end
      LOAD: begin
        pop        = 1'b1;
        byte_valid = 1'b1;
        byte_data  = head_reg[7:0];
        rest_next  = head_reg[31:8];
        idx_next   = 2'd0;
        state_next = START;
      end
      START: begin
        // byte_ready here is the final stop-bit cycle of the current byte.
        if (byte_ready) begin
          if (idx_reg != 2'(BYTES_PER_WORD - 1)) begin
            byte_valid = 1'b1;
            rest_next  = {8'h00, rest_reg[23:8]};
            idx_next   = idx_reg + 2'd1;
          end else if (!empty) begin
            state_next = LOAD;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= 2'd0;
      rest_reg  <= 24'd0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      rest_reg  <= rest_next;
    end
  end

  assign busy = !empty || (state_reg != IDLE);

  uart_byte_tx #(
    .CLK_PER_BIT (CLK_PER_BIT)
  ) u_byte_tx (
    .clk        (clk),
    .rst        (rst),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .txd        (txd)
  );

endmodule

// File: tb/tb_output_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_output_uart_tx
// Directed bench for output_uart_tx at CLK_PER_BIT=4, FIFO_DEPTH_LOG2=2.
// A negedge monitor decodes txd into bytes with start-cycle timestamps; a
// vector table drives single words and hand-written sequences cover
// back-to-back words, FIFO overflow and reset mid-frame.
// Honours OUTPUT_UART_TX_PARITY_EN (8E1 frames).
// -----------------------------------------------------------------------------
module tb_output_uart_tx;

  localparam int CPB = 4;
  localparam int FL2 = 2;
`ifdef OUTPUT_UART_TX_PARITY_EN
  localparam int  NB     = 11;
  localparam bit  PAR_EN = 1'b1;
`else
  localparam int  NB     = 10;
  localparam bit  PAR_EN = 1'b0;
`endif
  localparam int BF    = NB * CPB;   // cycles per byte frame
  localparam int FRAME = 4 * BF;     // cycles per word

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic        data_valid;
  logic        data_ready, txd, busy, overflow;

  output_uart_tx #(
    .CLK_PER_BIT     (CPB),
    .FIFO_DEPTH_LOG2 (FL2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .txd        (txd),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ------------------------------------------------------------ monitor
  logic [7:0] rx_b[$];
  int         rx_s[$];
  logic       rx_ok[$];
  logic       rx_p[$];
  bit         mon_active = 0;
  int         mon_t, mon_start, mon_bit;
  logic [7:0] mon_sh;
  logic       mon_ok, mon_p;

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      mon_active = 0;
    end else if (!mon_active) begin
      if (txd === 1'b0) begin
        mon_active = 1;
        mon_t      = 0;
        mon_start  = cyc;
        mon_ok     = 1'b1;
      end
    end else begin
      mon_t++;
      if (mon_t % CPB == CPB / 2) begin
        mon_bit = mon_t / CPB;
        if (mon_bit == 0) mon_ok = mon_ok & (txd === 1'b0);
        if (mon_bit >= 1 && mon_bit <= 8) mon_sh[mon_bit-1] = txd;
        if (mon_bit == 9) mon_p = txd;
        if (mon_bit == NB - 1) begin
          mon_ok = mon_ok & (txd === 1'b1);
          rx_b.push_back(mon_sh);
          rx_s.push_back(mon_start);
          rx_ok.push_back(mon_ok);
          rx_p.push_back(mon_p);
          mon_active = 0;
        end
      end
    end
  end

  task automatic clear_rx();
    rx_b.delete(); rx_s.delete(); rx_ok.delete(); rx_p.delete();
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check({name, " idle timeout"}, 32'(busy), 32'd0);
  endtask

  // Sends one word into an idle DUT and checks bytes, latency and busy drop.
  task automatic run_word(input logic [31:0] w, input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2, input logic [7:0] e3, input logic [3:0] ep);
    logic [7:0] exp_b [4];
    int         wr, s;
    exp_b = '{e0, e1, e2, e3};
    clear_rx();
    @(negedge clk);
    data_in = w; data_valid = 1'b1; wr = cyc;
    @(negedge clk);
    data_valid = 1'b0;
    s = wr + 3;
    for (int i = 0; i < FRAME + 20 && cyc != s + FRAME - 1; i++) @(negedge clk);
    check($sformatf("%h busy last cycle", w), 32'(busy), 32'd1);
    @(negedge clk);
    check($sformatf("%h busy after frame", w), 32'(busy), 32'd0);
    check($sformatf("%h byte count", w), 32'(rx_b.size()), 32'd4);
    if (rx_b.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("%h byte%0d", w, i), 32'(rx_b[i]), 32'(exp_b[i]));
        check($sformatf("%h byte%0d framing", w, i), 32'(rx_ok[i]), 32'd1);
        check($sformatf("%h byte%0d start cycle", w, i), 32'(rx_s[i]), 32'(s + i * BF));
        check($sformatf("%h byte%0d parity/stop", w, i), 32'(rx_p[i]),
              32'(PAR_EN ? ep[i] : 1'b1));
      end
    end
    $display("word %h: %0d bytes received, start at +%0d", w, rx_b.size(),
             (rx_s.size() > 0) ? rx_s[0] - wr : -1);
  endtask

  typedef struct {
    logic [31:0] word;
    logic [7:0]  b0, b1, b2, b3;
    logic [3:0]  par;   // par[i] = even parity of byte i
  } vec_t;

  vec_t vecs [5];

  initial begin
    int          bad, wr, s;
    logic [31:0] got, exp_w [5];

    vecs[0] = '{32'h12345678, 8'h78, 8'h56, 8'h34, 8'h12, 4'b0100};
    vecs[1] = '{32'h000000FF, 8'hFF, 8'h00, 8'h00, 8'h00, 4'b0000};
    vecs[2] = '{32'hA5A5A5A5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 4'b0000};
    vecs[3] = '{32'hDEADBEEF, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 4'b0101};
    vecs[4] = '{32'h00000107, 8'h07, 8'h01, 8'h00, 8'h00, 4'b0011};

    // ---------------------------------------------------------- reset
    rst = 1'b1; data_valid = 1'b0; data_in = 32'd0;
    repeat (3) @(negedge clk);
    check("reset txd", 32'(txd), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset data_ready", 32'(data_ready), 32'd1);
    check("reset overflow", 32'(overflow), 32'd0);
    rst = 1'b0;

    // ------------------------------------------------------- idle check
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0 || data_ready !== 1'b1) bad++;
    end
    check("idle 1000 cycles glitches", 32'(bad), 32'd0);
    $display("idle: 1000 cycles observed");

    // ----------------------------------------------------- vector table
    for (int v = 0; v < 5; v++)
      run_word(vecs[v].word, vecs[v].b0, vecs[v].b1, vecs[v].b2, vecs[v].b3, vecs[v].par);

    // ------------------------------------------------- back-to-back words
    clear_rx();
    @(negedge clk);
    data_in = 32'h000000FF; data_valid = 1'b1; wr = cyc;
    @(negedge clk);
    data_in = 32'hA5A5A5A5;
    @(negedge clk);
    data_valid = 1'b0;
    wait_idle("b2b", 3 * FRAME);
    s = wr + 3;
    check("b2b byte count", 32'(rx_b.size()), 32'd8);
    if (rx_b.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check($sformatf("b2b byte%0d", i), 32'(rx_b[i]), (i == 0) ? 32'hFF : (i < 4) ? 32'h00 : 32'hA5);
        check($sformatf("b2b byte%0d start", i), 32'(rx_s[i]), 32'(s + i * BF + ((i >= 4) ? 1 : 0)));
        check($sformatf("b2b byte%0d framing", i), 32'(rx_ok[i]), 32'd1);
      end
    end
    $display("back-to-back: %0d bytes received", rx_b.size());

    // ------------------------------------------------------- overflow
    clear_rx();
    @(negedge clk);
    data_in = 32'hCAFEF00D; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (10) @(negedge clk);
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 5) check("overflow before refusal", 32'(overflow), 32'd0);
      check($sformatf("ready word%0d", k), 32'(data_ready), (k <= 4) ? 32'd1 : 32'd0);
      data_in = 32'(k); data_valid = 1'b1;
    end
    @(negedge clk);
    data_valid = 1'b0;
    check("overflow set", 32'(overflow), 32'd1);
    wait_idle("overflow", 6 * FRAME);
    check("overflow sticky", 32'(overflow), 32'd1);
    check("overflow byte count", 32'(rx_b.size()), 32'd20);
    exp_w = '{32'hCAFEF00D, 32'd1, 32'd2, 32'd3, 32'd4};
    if (rx_b.size() == 20) begin
      for (int i = 0; i < 5; i++) begin
        got = {rx_b[4*i+3], rx_b[4*i+2], rx_b[4*i+1], rx_b[4*i]};
        check($sformatf("overflow word%0d", i), got, exp_w[i]);
      end
    end
    $display("overflow: %0d bytes received, overflow=%0b", rx_b.size(), overflow);

    // ------------------------------------------------ reset mid-frame
    clear_rx();
    @(negedge clk);
    data_in = 32'h11003344; data_valid = 1'b1; wr = cyc;
    @(negedge clk);
    data_in = 32'h55555555;
    @(negedge clk);
    data_in = 32'h66666666;
    @(negedge clk);
    data_valid = 1'b0;
    s = wr + 3;
    // Byte 2 is 0x00: every data bit is low, so a released line is visible.
    for (int i = 0; i < 200 && cyc != s + 2 * BF + 10; i++) @(negedge clk);
    check("rst: txd low before", 32'(txd), 32'd0);
    rst = 1'b1;
    #1;
    check("rst: txd immediate", 32'(txd), 32'd1);
    check("rst: busy", 32'(busy), 32'd0);
    check("rst: data_ready", 32'(data_ready), 32'd1);
    check("rst: overflow cleared", 32'(overflow), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_rx();
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("rst: queue discarded", 32'(bad), 32'd0);
    check("rst: no bytes after", 32'(rx_b.size()), 32'd0);
    $display("reset mid-frame: line released, queued words dropped");
    run_word(32'hDEADBEEF, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 4'b0101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/output_uart_tx.md
Name: output_uart_tx

Overview:
- Host-facing end of the core's output data port: accepts 32-bit words the CPU emits on its output path and streams them to the PC over UART, 8N1.
- Buffers words in a small FIFO, then serialises each word as 4 bytes, least-significant byte first.
- Instantiated in the top-level wrapper next to the core; drives the board TX pin.

Parameters:
- CLK_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200 baud); legal range 4..65535.
- FIFO_DEPTH_LOG2, 4, log2 of word FIFO depth (16 words).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- data_in  in  32  word from CPU output path.
- data_valid  in  1  data_in is valid this cycle.
- data_ready  out  1  FIFO not full; a word is accepted when data_valid && data_ready.
- txd  out  1  UART serial line, idle high.
- busy  out  1  high while the FIFO is non-empty or the serialiser is active.
- overflow  out  1  sticky; set when data_valid is high while data_ready is low.

Behaviour:
- Reset (async assert, sync release): txd=1, data_ready=1, busy=0, overflow=0, FIFO empty, FSM=IDLE, baud counter=0, byte index=0.
- FIFO:
  - Synchronous write on accept; read pointer advances when the serialiser loads a word.
  - Pointers are FIFO_DEPTH_LOG2+1 bits wide: full when the MSBs differ and the rest are equal; empty when all bits are equal.
  - data_ready = !full, combinational from the registered pointers.
  - Simultaneous write and read when full: the write is refused (ready is already low). When empty: the write lands, and the read happens no earlier than the next cycle.
- Word serialiser FSM (states IDLE, LOAD, START, DATA, STOP):
  - IDLE: if the FIFO is non-empty, go to LOAD.
  - LOAD: latch the FIFO head into shift word w, byte index=0, pop the FIFO, go to START.
  - START: txd=0 for CLK_PER_BIT cycles.
  - DATA: 8 bits of byte w[8*idx +: 8], LSB first, each held CLK_PER_BIT cycles.
  - STOP: txd=1 for CLK_PER_BIT cycles. Then if idx<3: idx++, go to START; else if the FIFO is non-empty go to LOAD, else go to IDLE.
- Baud counter counts 0..CLK_PER_BIT-1 and reloads on wrap. The bit counter (3 bits) wraps at 7 -> STOP.
- Latency: a word written into an empty FIFO at cycle N has its start bit on txd from cycle N+3. One word occupies exactly 40*CLK_PER_BIT cycles on the line.
- Back-to-back words add 1 LOAD cycle between the STOP of byte 3 and the next START.
- txd is registered (no glitches) and driven from the FSM state and shift data.
- overflow stays set until rst; the dropped word is discarded and does not disturb the FIFO.
- busy = !empty || (state != IDLE).
- rst asserted mid-frame: txd goes to 1 immediately (async) and all queued words are discarded.

Optional Feature:
- Macro: OUTPUT_UART_TX_PARITY_EN.
- Defined: an even-parity bit is inserted between DATA and STOP (new state PARITY, held CLK_PER_BIT cycles). Frame is 8E1, a word occupies 44*CLK_PER_BIT cycles, and the N+3 start-bit latency is unchanged.
- Undefined: 8N1 exactly as above, and no PARITY state exists in the encoding.

Decomposition:
- Package cpu_io_pkg holds:
  - the tx FSM state enum (IDLE, LOAD, START, DATA, STOP, PARITY);
  - BYTES_PER_WORD=4;
  - the default CLK_PER_BIT constant.
- Natural sub-module: uart_byte_tx (start/data/[parity]/stop for one byte with a valid/done handshake). output_uart_tx then holds the FIFO and the 4-byte sequencing.

Test Plan:
- CLK_PER_BIT=4, write 0x12345678 once -> txd shows the bytes 0x78, 0x56, 0x34, 0x12 (LSB first, 8N1). Start bit at cycle N+3, busy low after 160 cycles of frame.
- Write 0x000000FF then 0xA5A5A5A5 back-to-back -> 8 bytes, with exactly one idle-high LOAD cycle between words and none between bytes.
- FIFO_DEPTH_LOG2=2, hold data_valid with incrementing words 1..6 while the line is busy -> data_ready drops after 4 accepted, overflow=1, and only words 1-4 are transmitted.
- Pulse rst during the DATA bit of byte 2 -> txd=1 the same cycle, busy=0, FIFO empty. A following word 0xDEADBEEF transmits cleanly.
- With OUTPUT_UART_TX_PARITY_EN defined, send 0x00000107 -> parity bits 1, 1, 0, 0 for bytes 0x07, 0x01, 0x00, 0x00. Frame length is 176 cycles at CLK_PER_BIT=4.
- Idle check: no writes for 1000 cycles after reset -> txd constant 1, busy=0, data_ready=1.
